// File: rtl/sprite_rom_arb_pkg.sv
// Shared types and constants for the sprite ROM arbiter.
// Optional stall counters are enabled with SPRITE_ROM_ARBITER_PERF_EN.
package sprite_rom_arb_pkg;

   localparam int NUM_REQ_DEF = 3;
   localparam int ADDR_W_DEF  = 17;
   localparam int DATA_W_DEF  = 5;

   typedef enum logic [1:0] {
      REQ_BG = 2'd0,
      REQ_P1 = 2'd1,
      REQ_P2 = 2'd2
   } req_id_e;

   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after start wins.
// Purely combinational; one-hot grant plus binary winner index.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] start_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin
      int j;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(start_i) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM among pixel requesters.
// Define SPRITE_ROM_ARBITER_PERF_EN to add per-requester stall counters.
module sprite_rom_arbiter
   import sprite_rom_arb_pkg::*;
#(
   parameter  int NUM_REQ = NUM_REQ_DEF,
   parameter  int ADDR_W  = ADDR_W_DEF,
   parameter  int DATA_W  = DATA_W_DEF,
   parameter  int ROM_LAT = 1,
   localparam int ID_W    = id_w(NUM_REQ)
) (
   input  logic                      vga_clk,
   input  logic                      reset_n,
   input  logic                      line_start,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]         rom_address,
   output logic                      rom_rd,
   input  logic [DATA_W-1:0]         rom_q,
   output logic                      rvalid,
   output logic [ID_W-1:0]           rid,
   output logic [DATA_W-1:0]         rdata
`ifdef SPRITE_ROM_ARBITER_PERF_EN
  ,output logic [NUM_REQ*16-1:0]     perf_wait
`endif
);

   logic [NUM_REQ-1:0]           pick_gnt;
   logic [ID_W-1:0]              win;
   logic                         any;
   logic [ID_W-1:0]              start;
   logic [ID_W-1:0]              ptr_q, ptr_d;
   logic [ADDR_W-1:0]            win_addr;
   logic [ADDR_W-1:0]            rom_addr_q;
   logic [ROM_LAT:0]             vld_q;
   logic [ROM_LAT:0][ID_W-1:0]   id_q;

   // A new scanline restarts the search at the background layer.
   assign start = line_start ? '0 : ptr_q;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_pick (
      .req_i   (req),
      .start_i (start),
      .gnt_o   (pick_gnt),
      .idx_o   (win),
      .any_o   (any)
   );

   assign gnt = reset_n ? pick_gnt : '0;

   always_comb begin
      win_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_gnt[i]) begin
            win_addr = addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (any) begin
         ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q      <= '0;
         rom_addr_q <= '0;
         vld_q      <= '0;
         id_q       <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (any) begin
            rom_addr_q <= win_addr;
         end
         vld_q <= {vld_q[ROM_LAT-1:0], any};
         id_q  <= {id_q[ROM_LAT-1:0], win};
      end
   end

   // Stage 0 of the tag pipe is exactly the issue strobe.
   assign rom_address = rom_addr_q;
   assign rom_rd      = vld_q[0];
   assign rvalid      = vld_q[ROM_LAT];
   assign rid         = id_q[ROM_LAT];
   assign rdata       = rom_q;

`ifdef SPRITE_ROM_ARBITER_PERF_EN
   logic [NUM_REQ-1:0][15:0] wait_q;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (line_start) begin
               wait_q[i] <= '0;
            end else if (req[i] && !pick_gnt[i] && wait_q[i] != 16'hFFFF) begin
               wait_q[i] <= wait_q[i] + 16'd1;
            end
         end
      end
   end

   assign perf_wait = wait_q;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter with a queue-based reference.
// Stall-counter checks are compiled when SPRITE_ROM_ARBITER_PERF_EN is set.
module tb_sprite_rom_arbiter;

   localparam int NQ = 3;
   localparam int AW = 17;
   localparam int DW = 5;

   logic            vga_clk;
   logic            reset_n;
   logic            line_start;
   logic [NQ-1:0]   req;
   logic [NQ*AW-1:0] addr;
   logic [NQ-1:0]   gnt;
   logic [AW-1:0]   rom_address;
   logic            rom_rd;
   logic [DW-1:0]   rom_q;
   logic            rvalid;
   logic [1:0]      rid;
   logic [DW-1:0]   rdata;
`ifdef SPRITE_ROM_ARBITER_PERF_EN
   logic [NQ*16-1:0] perf_wait;
`endif

   sprite_rom_arbiter dut (
      .vga_clk     (vga_clk),
      .reset_n     (reset_n),
      .line_start  (line_start),
      .req         (req),
      .addr        (addr),
      .gnt         (gnt),
      .rom_address (rom_address),
      .rom_rd      (rom_rd),
      .rom_q       (rom_q),
      .rvalid      (rvalid),
      .rid         (rid),
      .rdata       (rdata)
`ifdef SPRITE_ROM_ARBITER_PERF_EN
     ,.perf_wait   (perf_wait)
`endif
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return a[4:0] ^ a[9:5] ^ a[16:12] ^ 5'd7;
   endfunction

   // One-cycle-latency ROM model.
   always @(posedge vga_clk) rom_q <= rom_f(rom_address);

   logic          rq_on   [NQ];
   logic [AW-1:0] rq_addr [NQ];

   always_comb begin
      req  = '0;
      addr = '0;
      for (int i = 0; i < NQ; i++) begin
         req[i]            = rq_on[i];
         addr[i*AW +: AW]  = rq_addr[i];
      end
   end

   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
   } ret_t;

   ret_t          q[$];
   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            ptr = 0;
   int            win_q = -1;
   logic          prev_any = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic          rand_mode = 1'b0;
   logic [NQ-1:0] last_gnt;
   logic [AW-1:0] last_addr;
   int            mw[NQ];
`ifdef SPRITE_ROM_ARBITER_PERF_EN
   logic [NQ*16-1:0] last_perf;
`endif

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic check();
      int st;
      int w;
      int j;
      logic [NQ-1:0] eg;
      last_gnt  = gnt;
      last_addr = rom_address;
`ifdef SPRITE_ROM_ARBITER_PERF_EN
      last_perf = perf_wait;
`endif
      if (!reset_n) begin
         chk("rst_gnt", 32'(gnt), 32'd0);
         chk("rst_rom_rd", 32'(rom_rd), 32'd0);
         chk("rst_rvalid", 32'(rvalid), 32'd0);
         chk("rst_rid", 32'(rid), 32'd0);
         chk("rst_rom_address", 32'(rom_address), 32'd0);
         q.delete();
         ptr       = 0;
         prev_any  = 1'b0;
         prev_addr = '0;
         win_q     = -1;
         for (int i = 0; i < NQ; i++) mw[i] = 0;
         cyc++;
         return;
      end
      st = line_start ? 0 : ptr;
      w  = -1;
      for (int k = 0; k < NQ; k++) begin
         j = (st + k) % NQ;
         if (w < 0 && rq_on[j]) w = j;
      end
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("rom_rd", 32'(rom_rd), 32'(prev_any));
      chk("rom_address", 32'(rom_address), 32'(prev_addr));
      if (q.size() > 0 && q[0].due == cyc) begin
         chk("rvalid", 32'(rvalid), 32'd1);
         chk("rid", 32'(rid), 32'(q[0].id));
         chk("rdata", 32'(rdata), 32'(q[0].data));
         void'(q.pop_front());
      end else begin
         chk("rvalid_idle", 32'(rvalid), 32'd0);
      end
`ifdef SPRITE_ROM_ARBITER_PERF_EN
      for (int i = 0; i < NQ; i++) begin
         chk("perf_wait", 32'(perf_wait[i*16 +: 16]), 32'(mw[i]));
      end
      for (int i = 0; i < NQ; i++) begin
         if (line_start) mw[i] = 0;
         else if (rq_on[i] && i != w && mw[i] < 65535) mw[i]++;
      end
`endif
      if (w >= 0) begin
         q.push_back('{due: cyc + 2, id: w, data: rom_f(rq_addr[w])});
         ptr       = (w + 1) % NQ;
         prev_any  = 1'b1;
         prev_addr = rq_addr[w];
      end else begin
         prev_any = 1'b0;
      end
      win_q = w;
      cyc++;
   endtask

   task automatic advance();
      for (int i = 0; i < NQ; i++) begin
         if (i == win_q) begin
            if (!rand_mode) rq_addr[i] = rq_addr[i] + 1'b1;
            else if ($urandom_range(0, 3) == 0) rq_on[i] = 1'b0;
            else rq_addr[i] = AW'($urandom);
         end else if (rand_mode) begin
            if (!rq_on[i] && $urandom_range(0, 2) == 0) begin
               rq_on[i]   = 1'b1;
               rq_addr[i] = AW'($urandom);
            end else if (rq_on[i] && $urandom_range(0, 15) == 0) begin
               rq_on[i] = 1'b0;
            end
         end
      end
      if (rand_mode) line_start = ($urandom_range(0, 15) == 0);
   endtask

   task automatic tick();
      @(negedge vga_clk);
      check();
      @(posedge vga_clk);
      #1;
      advance();
   endtask

   task automatic set_req(input logic [NQ-1:0] r);
      for (int i = 0; i < NQ; i++) rq_on[i] = r[i];
   endtask

   initial begin
      reset_n    = 1'b0;
      line_start = 1'b0;
      for (int i = 0; i < NQ; i++) begin
         rq_on[i]   = 1'b1;
         rq_addr[i] = AW'(16 * i + 5);
         mw[i]      = 0;
      end
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      chk("rr_first", 32'(last_gnt), 32'b001);
      tick();
      chk("rr_second", 32'(last_gnt), 32'b010);
      tick();
      chk("rr_third", 32'(last_gnt), 32'b100);
      tick();
      chk("rr_wrap", 32'(last_gnt), 32'b001);

      set_req(3'b010);
      rq_addr[1] = 17'd100;
      repeat (4) tick();
      chk("single_addr", 32'(last_addr), 32'd102);
      chk("single_gnt", 32'(last_gnt), 32'b010);

      set_req(3'b101);
      line_start = 1'b1;
      tick();
      chk("ls_restart", 32'(last_gnt), 32'b001);
      line_start = 1'b0;
      tick();
      chk("ls_next", 32'(last_gnt), 32'b100);

      set_req(3'b111);
      tick();
      set_req(3'b000);
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      repeat (3) tick();

      set_req(3'b111);
      repeat (2) tick();
      reset_n = 1'b0;
      set_req(3'b000);
      tick();
      reset_n = 1'b1;
      repeat (4) tick();
      set_req(3'b111);
      tick();
      chk("post_rst_ptr", 32'(last_gnt), 32'b001);

`ifdef SPRITE_ROM_ARBITER_PERF_EN
      set_req(3'b000);
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      set_req(3'b111);
      repeat (9) tick();
      set_req(3'b000);
      tick();
      for (int i = 0; i < NQ; i++) begin
         chk("perf_nine", 32'(last_perf[i*16 +: 16]), 32'd6);
      end
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      tick();
      for (int i = 0; i < NQ; i++) begin
         chk("perf_clear", 32'(last_perf[i*16 +: 16]), 32'd0);
      end
`endif

      rand_mode = 1'b1;
      repeat (400) tick();
      rand_mode  = 1'b0;
      line_start = 1'b0;
      set_req(3'b000);
      repeat (4) tick();
      chk("drained", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM (streetfighter_rom-style: address in, palette index out, fixed read latency) among NUM_REQ pixel requesters: background, player 1 and player 2 sprite engines.
- Round-robin arbitration, one grant per cycle.
- Drives the ROM address and returns each read's data tagged with the requester id.
- Sits between the per-layer sprite engines and the single ROM instance, ahead of the palette lookup.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 17, ROM address width.
- DATA_W, 5, ROM word (palette index) width.
- ROM_LAT, 1, ROM read latency in vga_clk cycles (1 or 2).

Ports:
- vga_clk  in  1  pixel clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- line_start  in  1  one-cycle pulse at the start of each scanline.
- req  in  NUM_REQ  per-requester read request, level.
- addr  in  NUM_REQ*ADDR_W  packed request addresses; slice i belongs to req[i].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the winning req.
- rom_address  out  ADDR_W  registered ROM address.
- rom_rd  out  1  registered: rom_address is a valid read this cycle.
- rom_q  in  DATA_W  ROM data; reflects the address presented ROM_LAT cycles earlier.
- rvalid  out  1  return data valid.
- rid  out  ID_W  requester index of the returning data; ID_W = max(1, clog2(NUM_REQ)).
- rdata  out  DATA_W  returned palette index; equals rom_q.

Behaviour:
- Reset (async assert, sync release):
  - gnt=0, rom_rd=0, rom_address=0, rvalid=0, rid=0.
  - Round-robin pointer ptr=0; tag pipeline cleared.
  - rdata is not reset; it passes through rom_q.
- Handshake:
  - A requester raises req[i] with a stable addr slice and holds both until it sees gnt[i] high in some cycle t.
  - gnt[i] lasts exactly one cycle per read. The requester may keep req high to issue back-to-back reads, updating addr after each grant.
  - Dropping req before a grant is legal; nothing is issued.
- Arbitration in cycle t:
  - Search req starting at index ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - If line_start=1 in cycle t, the search starts at index 0 regardless of ptr.
  - On a grant to winner w: ptr <= (w+1) mod NUM_REQ. With no request, ptr is unchanged.
  - A single active requester is granted every cycle (100% throughput).
- Issue: on the edge ending cycle t, rom_address <= winner's addr and rom_rd <= 1. Both are visible in cycle t+1. With no winner, rom_rd <= 0 and rom_address holds its value.
- Return: a (valid, id) tag shift register of depth 1+ROM_LAT.
  - rvalid=1 and rid=w in cycle t+1+ROM_LAT, with rdata=rom_q in that same cycle.
  - Fixed latency gnt→rvalid = 1+ROM_LAT (2 cycles for ROM_LAT=1). Returns arrive in grant order.
- Boundaries:
  - line_start does not flush the tag pipeline; in-flight reads still return.
  - Reset mid-operation drops all in-flight reads; no rvalid appears after reset release until a new grant.
  - rid for an unused encoding (NUM_REQ not a power of two) is never produced.
  - Addresses are passed through unchecked; range is the requester's responsibility.

Optional Feature:
- Macro: SPRITE_ROM_ARBITER_PERF_EN.
- With the macro defined:
  - Adds output perf_wait of width NUM_REQ*16.
  - Per requester, a 16-bit counter increments in each cycle where req[i]=1 and gnt[i]=0.
  - Each counter saturates at 16'hFFFF.
  - Each counter clears to 0 on reset and in the cycle after line_start, giving per-line stall counts.
- Without the macro: no perf_wait port and no counters; all other behaviour is identical.

Decomposition:
- Package sprite_rom_arb_pkg holds:
  - constants NUM_REQ_DEF=3, ADDR_W_DEF=17, DATA_W_DEF=5;
  - function id_w(n);
  - enum req_id_e {REQ_BG=0, REQ_P1=1, REQ_P2=2}.
- One sub-module, rr_pick: a purely combinational rotating-priority picker (req, start index → one-hot gnt, winner index, any). The top level holds ptr, the issue registers, the tag pipeline and the optional counters.

Test Plan:
- Reset with req=3'b111 held → gnt=0, rom_rd=0, rvalid=0 while reset_n=0. After release: gnt=001, then 010, then 100, then 001 on consecutive cycles.
- Only req[1] held, addr stepping 100,101,102 after each grant (ROM_LAT=1) → gnt[1] every cycle; rom_address=100,101,102 in cycles t+1..t+3; rvalid with rid=1 in cycles t+2..t+4; rdata matches the ROM model.
- ptr=2 (last grant to 1) and line_start=1 with req=3'b101 → gnt=001 (search restarts at 0). The next cycle with req=3'b101 → gnt=100.
- Grants in flight, then line_start pulse → all outstanding returns still appear with the correct rid, in grant order.
- reset_n pulsed low for 1 cycle with 2 reads outstanding → no rvalid after release; ptr=0.
- SPRITE_ROM_ARBITER_PERF_EN defined, req=3'b111 for 9 cycles → perf_wait per requester = 6 each; cleared after line_start; saturates at FFFF under a forced long stall.
